// File: rtl/nibbler_pkg.sv
// nibbler_pkg -- shared definitions for the nibbler control unit.
//   state_t    : controller FSM states (FETCH, EXEC, JADDR)
//   OP_*       : 4-bit opcode values found in IR[7:4]
//   ALU_*      : alu_sel encodings
//   strobe_t   : packed bundle of the datapath strobes
//   PC_W       : program counter width
package nibbler_pkg;

  localparam int PC_W = 12;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    JADDR = 2'b10
  } state_t;

  // Opcodes (IR[7:4])
  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_JZ    = 4'h2;
  localparam logic [3:0] OP_JNZ   = 4'h3;
  localparam logic [3:0] OP_NOP   = 4'h4;
  localparam logic [3:0] OP_CMPI  = 4'h5;
  localparam logic [3:0] OP_CMPM  = 4'h6;
  localparam logic [3:0] OP_LIT   = 4'h7;
  localparam logic [3:0] OP_IN    = 4'h8;
  localparam logic [3:0] OP_LD    = 4'h9;
  localparam logic [3:0] OP_ST    = 4'hA;
  localparam logic [3:0] OP_OUT   = 4'hB;
  localparam logic [3:0] OP_ADDI  = 4'hC;
  localparam logic [3:0] OP_ADDM  = 4'hD;
  localparam logic [3:0] OP_NANDI = 4'hE;
  localparam logic [3:0] OP_NANDM = 4'hF;

  // ALU function select
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;
  localparam logic [1:0] ALU_CMP  = 2'b11;

  // IR value loaded by reset: a NOP
  localparam logic [7:0] IR_RESET = 8'h40;

  typedef struct packed {
    logic flags_en;
    logic acc_en;
    logic ram_we;
    logic in_oe;
    logic out_we;
  } strobe_t;

  // Opcodes 0..3 carry a second (address) byte.
  function automatic logic is_jump(input logic [7:0] instr);
    return (instr[7:6] == 2'b00);
  endfunction

endpackage

// File: rtl/nibbler_decode.sv
// nibbler_decode -- combinational opcode-to-strobe table.
//   op      in  [3:0] : instruction opcode, IR[7:4]
//   strobes out       : datapath strobes for this opcode (ungated)
//   alu_sel out [1:0] : ALU function for this opcode
// Jump opcodes and NOP decode to no strobes; the caller gates the result
// so it only reaches the datapath during EXEC.
module nibbler_decode
  import nibbler_pkg::*;
(
  input  logic [3:0] op,
  output strobe_t    strobes,
  output logic [1:0] alu_sel
);

  always_comb begin
    strobes = '0;
    alu_sel = ALU_PASS;
    case (op)
      OP_CMPI, OP_CMPM: begin
        alu_sel          = ALU_CMP;
        strobes.flags_en = 1'b1;
      end
      OP_LIT: begin
        alu_sel        = ALU_PASS;
        strobes.acc_en = 1'b1;
      end
      OP_IN: begin
        strobes.in_oe  = 1'b1;
        strobes.acc_en = 1'b1;
      end
      OP_LD: strobes.acc_en = 1'b1;
      OP_ST: strobes.ram_we = 1'b1;
      OP_OUT: strobes.out_we = 1'b1;
      OP_ADDI, OP_ADDM: begin
        alu_sel          = ALU_ADD;
        strobes.acc_en   = 1'b1;
        strobes.flags_en = 1'b1;
      end
      OP_NANDI, OP_NANDM: begin
        alu_sel          = ALU_NAND;
        strobes.acc_en   = 1'b1;
        strobes.flags_en = 1'b1;
      end
      default: begin
        strobes = '0;
        alu_sel = ALU_PASS;
      end
    endcase
  end

endmodule

// File: rtl/nibbler_ctrl.sv
// nibbler_ctrl -- fetch/execute controller for the 4-bit nibbler CPU.
//   clk       in        : clock, all state changes on rising edge
//   rst       in        : synchronous active-high reset
//   prog_byte in  [7:0] : program ROM data at address pc
//   c_flag    in        : registered carry flag
//   z_flag    in        : registered zero flag
//   pc        out [11:0]: program counter / ROM address
//   oprnd     out [3:0] : IR[3:0]
//   alu_sel   out [1:0] : ALU function (00 outside EXEC)
//   flags_en, acc_en, ram_we, in_oe, out_we out : datapath strobes, EXEC only
//   retired   out [15:0]: retired-instruction count (only with
//                         NIBBLER_CTRL_RETIRE_CNT_EN defined)
// Every instruction takes two cycles: FETCH then EXEC, or FETCH then JADDR
// for jumps, whose second byte is read straight from prog_byte in JADDR.
module nibbler_ctrl
  import nibbler_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      prog_byte,
  input  logic            c_flag,
  input  logic            z_flag,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      oprnd,
  output logic [1:0]      alu_sel,
  output logic            flags_en,
  output logic            acc_en,
  output logic            ram_we,
  output logic            in_oe,
  output logic            out_we
`ifdef NIBBLER_CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0]     retired
`endif
);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [7:0]      ir_reg, ir_next;
  logic            jump_taken;

  strobe_t         dec_strobes;
  logic [1:0]      dec_alu_sel;
  strobe_t         strobes;

  nibbler_decode u_decode (
    .op      (ir_reg[7:4]),
    .strobes (dec_strobes),
    .alu_sel (dec_alu_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
      pc_reg    <= '0;
      ir_reg    <= IR_RESET;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  // Jump condition uses the flags as seen during JADDR itself.
  always_comb begin
    jump_taken = 1'b0;
    case (ir_reg[7:4])
      OP_JC:   jump_taken = c_flag;
      OP_JNC:  jump_taken = ~c_flag;
      OP_JZ:   jump_taken = z_flag;
      OP_JNZ:  jump_taken = ~z_flag;
      default: jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    case (state_reg)
      FETCH: begin
        ir_next    = prog_byte;
        pc_next    = pc_reg + 1'b1;  // wraps 0xFFF -> 0x000
        state_next = is_jump(prog_byte) ? JADDR : EXEC;
      end
      EXEC: begin
        state_next = FETCH;
      end
      JADDR: begin
        pc_next    = jump_taken ? {ir_reg[3:0], prog_byte} : pc_reg + 1'b1;
        state_next = FETCH;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Strobes and alu_sel reach the datapath only while executing.
  always_comb begin
    strobes = '0;
    alu_sel = ALU_PASS;
    if (state_reg == EXEC) begin
      strobes = dec_strobes;
      alu_sel = dec_alu_sel;
    end
  end

  assign pc       = pc_reg;
  assign oprnd    = ir_reg[3:0];
  assign flags_en = strobes.flags_en;
  assign acc_en   = strobes.acc_en;
  assign ram_we   = strobes.ram_we;
  assign in_oe    = strobes.in_oe;
  assign out_we   = strobes.out_we;

`ifdef NIBBLER_CTRL_RETIRE_CNT_EN
  logic [15:0] retired_reg;

  // EXEC and JADDR always hand back to FETCH, so leaving either retires one.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= '0;
    end else if (state_reg == EXEC || state_reg == JADDR) begin
      retired_reg <= retired_reg + 16'd1;
    end
  end

  assign retired = retired_reg;
`endif

endmodule

// File: tb/tb_nibbler_ctrl.sv
// tb_nibbler_ctrl -- self-checking bench for nibbler_ctrl.
// An instruction-level interpreter walks the ROM image and predicts pc,
// oprnd and strobes for both cycles of every instruction.
module tb_nibbler_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  prog_byte;
  logic        c_flag, z_flag;
  logic [11:0] pc;
  logic [3:0]  oprnd;
  logic [1:0]  alu_sel;
  logic        flags_en, acc_en, ram_we, in_oe, out_we;
`ifdef NIBBLER_CTRL_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  logic [7:0]  rom [4096];
  assign prog_byte = rom[pc];

  int          checks = 0;
  int          errors = 0;
  logic [11:0] mpc;
  int          m_retired;

  nibbler_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .prog_byte (prog_byte),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .pc        (pc),
    .oprnd     (oprnd),
    .alu_sel   (alu_sel),
    .flags_en  (flags_en),
    .acc_en    (acc_en),
    .ram_we    (ram_we),
    .in_oe     (in_oe),
    .out_we    (out_we)
`ifdef NIBBLER_CTRL_RETIRE_CNT_EN
    ,
    .retired   (retired)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {alu_sel, flags_en, acc_en, ram_we, in_oe, out_we} expected in EXEC
  function automatic logic [6:0] exp_ctl(input logic [3:0] op);
    case (op)
      4'h5, 4'h6: return 7'b11_10000;
      4'h7:       return 7'b00_01000;
      4'h8:       return 7'b00_01010;
      4'h9:       return 7'b00_01000;
      4'hA:       return 7'b00_00100;
      4'hB:       return 7'b00_00001;
      4'hC, 4'hD: return 7'b01_11000;
      4'hE, 4'hF: return 7'b10_11000;
      default:    return 7'b00_00000;
    endcase
  endfunction

  function automatic logic [6:0] act_ctl();
    return {alu_sel, flags_en, acc_en, ram_we, in_oe, out_we};
  endfunction

  task automatic check_retired();
`ifdef NIBBLER_CTRL_RETIRE_CNT_EN
    check_eq("retired", 32'(retired), 32'(m_retired[15:0]));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check_eq("rst_pc", 32'(pc), 32'h000);
    check_eq("rst_ctl", 32'(act_ctl()), 32'h0);
    check_eq("rst_oprnd", 32'(oprnd), 32'h0);
    rst = 1'b0;
    mpc = 12'h000;
    m_retired = 0;
    check_retired();
  endtask

  // Runs one instruction starting in FETCH; flags are held for its duration.
  task automatic run_instr(input logic fc, input logic fz);
    logic [7:0]  b;
    logic [11:0] tgt;
    logic        taken;
    b = rom[mpc];
    c_flag = fc;
    z_flag = fz;
    check_eq("fetch_pc", 32'(pc), 32'(mpc));
    check_eq("fetch_ctl", 32'(act_ctl()), 32'h0);
    step();
    mpc = mpc + 12'd1;
    check_eq("c2_pc", 32'(pc), 32'(mpc));
    check_eq("c2_oprnd", 32'(oprnd), 32'(b[3:0]));
    if (b[7:6] == 2'b00) begin
      check_eq("jaddr_ctl", 32'(act_ctl()), 32'h0);
      case (b[5:4])
        2'd0: taken = fc;
        2'd1: taken = !fc;
        2'd2: taken = fz;
        default: taken = !fz;
      endcase
      tgt = {b[3:0], rom[mpc]};
      step();
      mpc = taken ? tgt : mpc + 12'd1;
    end else begin
      check_eq("exec_ctl", 32'(act_ctl()), 32'(exp_ctl(b[7:4])));
      step();
    end
    m_retired++;
    check_retired();
  endtask

  initial begin
    rst = 1'b1;
    c_flag = 1'b0;
    z_flag = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h40;

    // Directed program: ADDI, JZ not taken, JNZ taken, JZ to 0xFFF, wrap.
    rom[12'h000] = 8'hC5;
    rom[12'h001] = 8'h2A; rom[12'h002] = 8'h34;
    rom[12'h003] = 8'h3A; rom[12'h004] = 8'h34;
    rom[12'hA34] = 8'h2F; rom[12'hA35] = 8'hFF;
    rom[12'hFFF] = 8'h40;
    do_reset();
    run_instr(1'b0, 1'b0);                  // ADDI 5
    run_instr(1'b0, 1'b0);                  // JZ not taken -> 0x003
    check_eq("jz_nt_pc", 32'(pc), 32'h003);
    run_instr(1'b0, 1'b0);                  // JNZ taken -> 0xA34
    check_eq("jnz_t_pc", 32'(pc), 32'hA34);
    run_instr(1'b0, 1'b1);                  // JZ taken -> 0xFFF
    check_eq("jz_t_pc", 32'(pc), 32'hFFF);
    run_instr(1'b0, 1'b0);                  // NOP at 0xFFF wraps
    check_eq("wrap_pc", 32'(pc), 32'h000);
    run_instr(1'b0, 1'b0);                  // ADDI again
    run_instr(1'b0, 1'b1);                  // JZ taken -> 0xA34
    check_eq("jz_t2_pc", 32'(pc), 32'hA34);

    // Reset in JADDR of a JC whose condition is true.
    rom[12'h000] = 8'h0A; rom[12'h001] = 8'h34;
    do_reset();
    c_flag = 1'b1;
    step();                                 // now in JADDR
    rst = 1'b1;
    step();
    check_eq("mid_jaddr_pc", 32'(pc), 32'h000);
    check_eq("mid_jaddr_ctl", 32'(act_ctl()), 32'h0);
    m_retired = 0;
    check_retired();
    step();
    rst = 1'b0;
    mpc = 12'h000;
    run_instr(1'b0, 1'b0);                  // JC not taken now -> 0x002
    check_eq("after_rst_pc", 32'(pc), 32'h002);

    // Reset in EXEC of ADDI: no strobe after the reset edge.
    rom[12'h000] = 8'hC5;
    do_reset();
    step();                                 // now in EXEC
    check_eq("pre_rst_exec_ctl", 32'(act_ctl()), 32'(exp_ctl(4'hC)));
    rst = 1'b1;
    step();
    check_eq("mid_exec_ctl", 32'(act_ctl()), 32'h0);
    check_eq("mid_exec_pc", 32'(pc), 32'h000);
    step();
    rst = 1'b0;
    mpc = 12'h000;
    m_retired = 0;
    run_instr(1'b0, 1'b0);

    // Random program with random flags.
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    do_reset();
    for (int n = 0; n < 400; n++) begin
      run_instr(1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibbler_ctrl.md
NIBBLER_CTRL -- requirements
Module: nibbler_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port prog_byte, input, 8 bits: program-ROM data at address pc.
REQ-004 SHALL have port c_flag, input, 1 bit: registered carry from the flags stage.
REQ-005 SHALL have port z_flag, input, 1 bit: registered zero from the flags stage.
REQ-006 SHALL have port pc, output, 12 bits: program counter, the ROM address.
REQ-007 SHALL have port oprnd, output, 4 bits: low nibble of the instruction register (IR[3:0]).
REQ-008 SHALL have port alu_sel, output, 2 bits: 00 pass, 01 add, 10 nand, 11 compare (subtract).
REQ-009 SHALL have port flags_en, output, 1 bit: drives the enabled input of the flags stage.
REQ-010 SHALL have ports acc_en, ram_we, in_oe and out_we, output, 1 bit each: datapath strobes.

Function
REQ-011 SHALL implement FSM states FETCH, EXEC and JADDR, with encodings held in the shared package.
- FETCH: IR <= prog_byte; pc <= pc+1.
- If prog_byte[7:6]==00 (jump class), next state is JADDR; otherwise next state is EXEC.
REQ-012 SHALL, in EXEC, assert the strobes for exactly one cycle according to IR[7:4], then return to FETCH:
- 4 NOP: no strobe.
- 5 CMPI / 6 CMPM: alu_sel=11, flags_en=1.
- 7 LIT: acc_en=1, alu_sel=00.
- 8 IN: in_oe=1, acc_en=1.
- 9 LD: acc_en=1.
- A ST: ram_we=1.
- B OUT: out_we=1.
- C ADDI / D ADDM: alu_sel=01, acc_en=1, flags_en=1.
- E NANDI / F NANDM: alu_sel=10, acc_en=1, flags_en=1.
REQ-013 SHALL decode jump opcodes 0 JC, 1 JNC, 2 JZ, 3 JNZ.
- Target = {IR[3:0], prog_byte}, where prog_byte is the second byte, read in JADDR.
REQ-014 SHALL, in JADDR, evaluate the condition from c_flag/z_flag sampled in that same cycle, then return to FETCH.
- Taken: pc <= target.
- Not taken: pc <= pc+1.
REQ-015 SHALL deassert all strobes (flags_en, acc_en, ram_we, in_oe, out_we) in FETCH and JADDR; alu_sel=00 outside EXEC.
REQ-016 SHALL wrap pc from 0xFFF to 0x000 on increment, with no error indication.
REQ-017 SHALL make flags written by an EXEC visible to a following jump, because at least one FETCH lies between them; no bypass is needed.
REQ-018 SHALL have fixed latencies: non-jump instruction 2 cycles; jump 2 cycles, taken or not.

Reset
REQ-019 SHALL, when rst=1 at a clock edge, set:
- state=FETCH, pc=0x000, IR=0x40 (NOP).
- all strobes=0, alu_sel=00.
REQ-020 SHALL give rst priority over any state, including mid-EXEC and mid-JADDR; the partial instruction is abandoned with no strobe issued after that edge.

Configuration
REQ-021 SHALL, with macro NIBBLER_CTRL_RETIRE_CNT_EN defined, add output retired (16 bits):
- Increments on each EXEC→FETCH and JADDR→FETCH transition.
- Wraps at 0xFFFF; cleared by rst.
REQ-022 SHALL, without NIBBLER_CTRL_RETIRE_CNT_EN, omit the retired port and counter; all other behaviour is identical.

Structure
REQ-023 SHALL place in package nibbler_pkg: the state enum, 4-bit opcode constants, alu_sel constants, and PC_W=12.
REQ-024 SHALL implement the opcode→strobe table as combinational sub-module nibbler_decode (input IR[7:4], outputs the strobe vector and alu_sel), gated by state==EXEC in nibbler_ctrl.

Verification
REQ-025 Reset: rst=1 for 2 cycles in any state -> pc=0x000, all strobes 0; first FETCH after release reads address 0x000.
REQ-026 ALU op: ROM[0]=0xC5 (ADDI 5) -> cycle 2 shows alu_sel=01, acc_en=1, flags_en=1, oprnd=5; pc=0x001.
REQ-027 Taken jump: ROM[1..2]=0x2A,0x34 (JZ 0xA34) with z_flag=1 -> pc=0xA34 after 2 cycles, no strobes asserted.
REQ-028 Not-taken jump: same code with z_flag=0 -> pc=0x003; JNZ with z_flag=0 -> pc=0xA34.
REQ-029 Wrap: pc=0xFFF, ROM=0x40 -> pc=0x000 after FETCH.
REQ-030 Mid-op reset: rst asserted in JADDR of JC (c_flag=1) -> pc=0x000, jump not taken; with NIBBLER_CTRL_RETIRE_CNT_EN, retired=0.
